// File: rtl/seg_reader.sv
// seg_reader: observes a multiplexed, active-low 4-digit seven-segment display
// bus and recovers the hex digits being shown on it.
//
// A {an,seg} sample must stay unchanged for STABLE_CYCLES consecutive edges
// before it is captured. Only samples that select exactly one digit are
// accepted. A frame_done pulse follows once all four digits have been
// captured since the previous frame.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   seg[6:0]     active-low segments {g,f,e,d,c,b,a}
//   an[3:0]      active-low digit enables
//   clear        synchronous clear of all captured state
//   value[15:0]  decoded hex nibbles, digit i in value[4i+3:4i]
//   digit_valid  per-digit flag: the nibble holds a legal glyph
//   err          sticky per-digit flag: an illegal pattern was captured
//   frame_done   one-cycle pulse after all four digits were captured
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic [3:0]  err,
  output logic        frame_done
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;
  localparam logic [3:0] STABLE  = 4'(STABLE_CYCLES);

  logic [10:0] sample_reg;
  logic [3:0]  count_reg;
  logic [3:0]  count_next;
  logic [3:0]  seen_reg;
  logic [0:0]  state_reg;

  logic [10:0] sample_in;
  logic        capture;
  logic        one_hot;
  logic [3:0]  dsel;
  logic [6:0]  lit;
  logic        legal;
  logic        blank;
  logic [3:0]  code;
  logic        accept;
  logic [3:0]  seen_upd;

  assign sample_in = {an, seg};
  assign lit       = ~seg;
  assign blank     = (lit == 7'b0000000);

  always_comb begin
    if (sample_in != sample_reg)
      count_next = 4'd1;
    else if (count_reg == 4'hF)
      count_next = count_reg;
    else
      count_next = count_reg + 4'd1;
  end

  // Only the edge that moves the counter onto STABLE captures; a saturated
  // counter sitting at STABLE (STABLE_CYCLES=15) must not re-trigger.
  assign capture = (count_next == STABLE) && (count_reg != STABLE);

  always_comb begin
    one_hot = 1'b1;
    dsel    = 4'b0000;
    case (an)
      4'b1110: dsel = 4'b0001;
      4'b1101: dsel = 4'b0010;
      4'b1011: dsel = 4'b0100;
      4'b0111: dsel = 4'b1000;
      default: one_hot = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    code  = 4'h0;
    case (lit)
      7'b0111111: code = 4'h0;
      7'b0000110: code = 4'h1;
      7'b1011011: code = 4'h2;
      7'b1001111: code = 4'h3;
      7'b1100110: code = 4'h4;
      7'b1101101: code = 4'h5;
      7'b1111101: code = 4'h6;
      7'b0000111: code = 4'h7;
      7'b1111111: code = 4'h8;
      7'b1101111: code = 4'h9;
      7'b1110111: code = 4'hA;
      7'b1111100: code = 4'hB;
      7'b0111001: code = 4'hC;
      7'b1011110: code = 4'hD;
      7'b1111001: code = 4'hE;
      7'b1110001: code = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  assign accept   = capture && one_hot;
  assign seen_upd = seen_reg | (accept ? dsel : 4'b0000);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_reg  <= '1;
      count_reg   <= 4'd0;
      seen_reg    <= 4'b0000;
      state_reg   <= COLLECT;
      value       <= 16'h0000;
      digit_valid <= 4'b0000;
      err         <= 4'b0000;
    end else begin
      // The sample register tracks the bus even during clear.
      sample_reg <= sample_in;
      if (clear) begin
        count_reg   <= 4'd0;
        seen_reg    <= 4'b0000;
        state_reg   <= COLLECT;
        value       <= 16'h0000;
        digit_valid <= 4'b0000;
        err         <= 4'b0000;
      end else begin
        count_reg <= count_next;
        if (accept) begin
          for (int i = 0; i < 4; i++) begin
            if (dsel[i]) begin
              if (legal) begin
                value[4*i +: 4] <= code;
                digit_valid[i]  <= 1'b1;
              end else if (blank) begin
                value[4*i +: 4] <= 4'h0;
                digit_valid[i]  <= 1'b0;
              end else begin
                digit_valid[i]  <= 1'b0;
                err[i]          <= 1'b1;
              end
            end
          end
        end
        if (state_reg == COLLECT) begin
          seen_reg <= seen_upd;
          if (seen_upd == 4'hF)
            state_reg <= DONE;
        end else begin
          // Leaving DONE wipes seen, but a capture on this very edge still
          // counts toward the next frame.
          seen_reg  <= accept ? dsel : 4'b0000;
          state_reg <= COLLECT;
        end
      end
    end
  end

  assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_seg_reader.sv
module tb_seg_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic        clear = 1'b0;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  err;
  logic        frame_done;

  seg_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .resetn(resetn), .seg(seg), .an(an), .clear(clear),
    .value(value), .digit_valid(digit_valid), .err(err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dv;
    logic [3:0]  err;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: digit contents, flags, frame bookkeeping and the raw
  // history of bus samples since the last reset/clear.
  logic [6:0]  lits[16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                            7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  logic [3:0]  m_nib[4];
  logic [3:0]  m_dv, m_err, m_seen;
  logic        m_done;
  logic [10:0] hist[$];

  task automatic model_zero();
    for (int d = 0; d < 4; d++) m_nib[d] = 4'h0;
    m_dv = 0; m_err = 0; m_seen = 0; m_done = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    int run, d, zeros, code;
    logic [3:0] cap;
    logic [6:0] l;
    if (!resetn || clear) begin
      model_zero();
      return;
    end
    hist.push_back({an, seg});
    if (hist.size() > 16) void'(hist.pop_front());
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] == hist[hist.size()-1]) run++;
      else break;
    end
    cap = 0;
    zeros = 0; d = 0;
    for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; d = k; end
    if (run == S && zeros == 1) begin
      l = ~seg;
      code = -1;
      for (int c = 0; c < 16; c++) if (lits[c] == l) code = c;
      if (code >= 0) begin
        m_nib[d] = 4'(code); m_dv[d] = 1;
      end else if (l == 0) begin
        m_nib[d] = 0; m_dv[d] = 0;
      end else begin
        m_dv[d] = 0; m_err[d] = 1;
      end
      cap[d] = 1;
    end
    if (m_done) begin
      m_done = 0;
      m_seen = cap;
    end else begin
      m_seen |= cap;
      if (m_seen == 4'hF) m_done = 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
    e.dv = m_dv; e.err = m_err; e.fd = m_done;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the expected post-edge outputs.
  task automatic step(input logic [3:0] a, input logic [6:0] lit_v, input logic clr);
    @(negedge clk);
    an = a; seg = ~lit_v; clear = clr;
    model_edge();
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] lit_v, input int n);
    for (int k = 0; k < n; k++) step(a, lit_v, 1'b0);
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 0;
    #1;
    vectors++;
    if ({value, digit_valid, err, frame_done} != 0) begin
      miscompares++;
      $display("FAIL async_reset: got value=%h dv=%b err=%b fd=%b, want all zero",
               value, digit_valid, err, frame_done);
    end
    step(an, ~seg, 1'b0);
    @(negedge clk);
    resetn = 1;
  endtask

  // Monitor: outputs are always presented, so compare once per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (value !== e.value || digit_valid !== e.dv || err !== e.err || frame_done !== e.fd) begin
          miscompares++;
          $display("FAIL outputs @%0t: got value=%h dv=%b err=%b fd=%b, want value=%h dv=%b err=%b fd=%b",
                   $time, value, digit_valid, err, frame_done, e.value, e.dv, e.err, e.fd);
        end else begin
          $display("vec %0d: an=%b seg=%b clr=%b value=%h dv=%b err=%b fd=%b",
                   vectors, an, seg, clear, value, digit_valid, err, frame_done);
        end
      end
    end
  end

  initial begin
    logic [6:0] l;
    int d, n, kind;
    model_zero();
    repeat (2) @(negedge clk);
    step(4'hF, 7'h00, 1'b0);       // held in reset
    @(negedge clk);
    resetn = 1;

    // Single digit '3' held 6 edges.
    hold(4'b1110, 7'b1001111, 6);
    // Scan 1, A, d, F across digits 0..3.
    hold(an_of(0), lits[1], 5);
    hold(an_of(1), lits[10], 5);
    hold(an_of(2), lits[13], 5);
    hold(an_of(3), lits[15], 5);
    hold(4'hF, 7'h00, 3);
    // Illegal pattern on digit 2, then a full further frame, then clear.
    hold(an_of(2), 7'b1000000, 5);
    for (int k = 0; k < 4; k++) hold(an_of(k), lits[k+4], 5);
    hold(4'hF, 7'h00, 2);
    step(4'hF, 7'h00, 1'b1);
    // Glitch: 3 edges, 1 different, 3 restored; then two digits lit at once.
    hold(an_of(1), lits[2], 3);
    hold(an_of(1), lits[3], 1);
    hold(an_of(1), lits[2], 3);
    hold(4'b1100, lits[8], 10);
    // Blank capture clears a valid digit.
    hold(an_of(0), lits[9], 5);
    hold(an_of(0), 7'h00, 5);
    // Reset after two digits captured; next frame needs all four again.
    hold(an_of(0), lits[6], 5);
    hold(an_of(1), lits[7], 5);
    hold(an_of(1), lits[7], 2);
    pulse_reset();
    for (int k = 0; k < 4; k++) hold(an_of(k), lits[15-k], 5);
    hold(an_of(0), lits[0], 2);

    // Randomised scanning with glitches, bad enables, illegal glyphs, clears.
    for (int t = 0; t < 120; t++) begin
      d = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      if (kind < 6) l = lits[$urandom_range(0, 15)];
      else if (kind < 7) l = 7'h00;
      else l = 7'($urandom);
      n = $urandom_range(1, 7);
      if ($urandom_range(0, 9) == 0) hold(4'($urandom), l, n);
      else hold(an_of(d), l, n);
      if ($urandom_range(0, 24) == 0) step(an, ~seg, 1'b1);
      if (t == 60) pulse_reset();
    end

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
